// File: rtl/cuckoo_lookup_pipe.sv
// Multi-channel cuckoo-hash exact-match lookup: hash -> pointer tables -> entry table -> compare.
// Optional per-channel hit counters are compiled in with `define CUCKOO_HIT_CNT_EN.
module cuckoo_lookup_pipe #(
  parameter int HASH_W = 10,
  parameter int IDX_W  = 9,
  parameter int KEY_W  = 40,
  parameter int SUF_W  = 2,
  parameter int CH     = 2,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1,
  localparam int CFG_AW = (HASH_W > IDX_W) ? HASH_W : IDX_W,
  localparam int ENT_W  = 1 + SUF_W + KEY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*HASH_W-1:0]  prehash_t1,
  input  logic [CH*HASH_W-1:0]  prehash_t2,
  input  logic [CH*8-1:0]       byte_in,
  input  logic [CH*KEY_W-1:0]   key_in,
  output logic                  out_valid,
  output logic [CH*2-1:0]       hit,
  output logic [CH*SUF_W-1:0]   suffix,
`ifdef CUCKOO_HIT_CNT_EN
  output logic [CH*32-1:0]      hit_cnt,
  input  logic                  cnt_clr,
`endif
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CFG_AW-1:0]     cfg_addr,
  input  logic [ENT_W-1:0]      cfg_data
);

  // Handshake: a beat is accepted on a rising edge where in_valid & in_ready;
  // in_ready drops whenever the pipeline is frozen (enable low or a table write).
  logic adv;
  assign in_ready = enable & ~cfg_we;
  assign adv      = in_ready;

  function automatic logic [HASH_W-1:0] hash_f(input logic [HASH_W-1:0] h,
                                               input logic [7:0] b);
    logic [HASH_W-1:0] sum;
    sum = (h << 3) + (h >> 3) + HASH_W'(b);
    return sum ^ h;
  endfunction

  logic                v1, v2, v3;
  logic [CH*KEY_W-1:0] k1, k2, k3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      k1        <= '0;
      k2        <= '0;
      k3        <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      k1        <= key_in;
      k2        <= k1;
      k3        <= k2;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [IDX_W-1:0]  t1_mem  [2**HASH_W];
    logic [IDX_W-1:0]  t2_mem  [2**HASH_W];
    logic [ENT_W-1:0]  ent_mem [2**IDX_W];

    logic [HASH_W-1:0] a1_q, a2_q;
    logic [IDX_W-1:0]  pa_q, pb_q;
    logic [ENT_W-1:0]  ea_q, eb_q;
    logic [1:0]        hit_q;
    logic [SUF_W-1:0]  suf_q;
    logic              wr_en;
    logic              hit_a, hit_b;
    logic [SUF_W-1:0]  suf_d;

    // Out-of-range channel numbers never match any g, so such writes are dropped.
    assign wr_en = cfg_we && (cfg_ch == CH_W'(g));

    // Tables have no reset: rule content survives rst.
    always_ff @(posedge clk) begin
      if (wr_en && cfg_sel == 2'd0)
        t1_mem[cfg_addr[HASH_W-1:0]] <= cfg_data[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (wr_en && cfg_sel == 2'd1)
        t2_mem[cfg_addr[HASH_W-1:0]] <= cfg_data[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (wr_en && cfg_sel == 2'd2)
        ent_mem[cfg_addr[IDX_W-1:0]] <= cfg_data;
    end

    assign hit_a = ea_q[ENT_W-1] && (ea_q[KEY_W-1:0] == k3[g*KEY_W +: KEY_W]);
    assign hit_b = eb_q[ENT_W-1] && (eb_q[KEY_W-1:0] == k3[g*KEY_W +: KEY_W]);

    // Candidate A wins when both match.
    always_comb begin
      suf_d = '0;
      if (hit_a)
        suf_d = ea_q[KEY_W +: SUF_W];
      else if (hit_b)
        suf_d = eb_q[KEY_W +: SUF_W];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a1_q  <= '0;
        a2_q  <= '0;
        pa_q  <= '0;
        pb_q  <= '0;
        ea_q  <= '0;
        eb_q  <= '0;
        hit_q <= '0;
        suf_q <= '0;
      end else if (adv) begin
        a1_q <= hash_f(prehash_t1[g*HASH_W +: HASH_W], byte_in[g*8 +: 8]);
        a2_q <= hash_f(prehash_t2[g*HASH_W +: HASH_W], byte_in[g*8 +: 8]);
        pa_q <= t1_mem[a1_q];
        pb_q <= t2_mem[a2_q];
        ea_q <= ent_mem[pa_q];
        eb_q <= ent_mem[pb_q];
        // Bubbles leave the last result visible.
        if (v3) begin
          hit_q <= {hit_b, hit_a};
          suf_q <= suf_d;
        end
      end
    end

    assign hit[g*2 +: 2]        = hit_q;
    assign suffix[g*SUF_W +: SUF_W] = suf_q;

`ifdef CUCKOO_HIT_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (cnt_clr)
        cnt_q <= '0;
      else if (adv && v3 && (hit_a || hit_b) && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end

    assign hit_cnt[g*32 +: 32] = cnt_q;
`endif
  end

endmodule

// File: doc/cuckoo_lookup_pipe.md
# cuckoo_lookup_pipe

Parametrised, multi-channel cuckoo-hash exact-match lookup stage for the payload engine. Per channel it folds one payload byte into two rolling pre-hashes, reads two pointer tables, reads the two candidate pattern entries, and compares them against the pipelined key window, producing a hit/suffix result four accepted beats later. Unlike the fixed-length, two-channel, read-only predecessor, it is generic in hash width, pointer depth, key length and channel count, carries a valid/stall handshake, and has a runtime table-write port for rule updates.

## Interface
- HASH_W, 10: pre-hash and pointer-table address width.
- IDX_W, 9: entry-table address width (pointer-table data width).
- KEY_W, 40: compared key width (pattern bytes × 8).
- SUF_W, 2: suffix field width.
- CH, 2: independent lookup channels (channel 0 = case-sensitive, 1 = nocase by convention).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  pipeline advance; 0 freezes every stage.
- in_valid  in  1  input beat valid.
- in_ready  out  1  = enable & ~cfg_we; beat accepted when in_valid & in_ready.
- prehash_t1, prehash_t2  in  CH*HASH_W  per-channel rolling pre-hashes.
- byte_in  in  CH*8  per-channel new payload byte.
- key_in  in  CH*KEY_W  per-channel key window to compare.
- out_valid  out  1  result valid.
- hit  out  CH*2  per channel {hitB, hitA}.
- suffix  out  CH*SUF_W  per-channel suffix of the winning entry.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  2  0 = T1 pointer table, 1 = T2 pointer table, 2 = entry table, 3 = ignored.
- cfg_ch  in  clog2(CH) (min 1)  target channel.
- cfg_addr  in  max(HASH_W,IDX_W)  write address (LSBs used).
- cfg_data  in  1+SUF_W+KEY_W  write data; entry format {valid, suffix, key}; pointer writes use LSB IDX_W bits.

## Operation
- Hash (S1, registered): addr = ((h<<3) + (h>>3) + byte) ^ h, all truncated to HASH_W; computed for T1 and T2 per channel.
- S2: synchronous read of T1[addr1], T2[addr2] (each 2^HASH_W × IDX_W per channel) → pointers pA, pB.
- S3: dual-port synchronous read of entry table (2^IDX_W × (1+SUF_W+KEY_W) per channel) at pA (port A), pB (port B).
- S4 (registered): hitA = entA.valid & (entA.key == key); hitB likewise. suffix = entA.suffix if hitA, else entB.suffix if hitB, else 0. Both hit → hit = 2'b11, suffix from A.
- key_in and in_valid travel in a 4-deep shift alongside each stage; pipeline valid bits gate out_valid.
- cfg_we = 1: in_ready = 0, pipeline frozen that cycle (as enable = 0); write commits at the clock edge; the next cycle's reads see new data.
- cfg_sel = 3 or cfg_ch ≥ CH: write discarded, stall still applied.
- Tables are never cleared by rst; power-up content zero, so entry valid = 0 and no hits until programmed.

## Timing
- Latency: exactly 4 advancing cycles from acceptance to out_valid; stall cycles add 1:1.
- Throughput: one beat per cycle while enable = 1, cfg_we = 0.
- in_valid = 0 with enable = 1 inserts a bubble (out_valid = 0 four cycles later); hit/suffix then hold their previous values.
- enable = 0: all pipeline registers, RAM output registers and outputs hold.
- Reset values: out_valid 0, hit 0, suffix 0, all stage valid bits and hash registers 0, in_ready follows its combinational definition. rst mid-stream drops all in-flight beats; no partial result emerges after release.
- Hash sum wraps modulo 2^HASH_W; no carry out.

## Configuration
- CUCKOO_HIT_CNT_EN defined: adds output hit_cnt (CH*32) and input cnt_clr (1). Per channel, a 32-bit counter increments on each out_valid cycle with any hit bit set, saturates at 0xFFFFFFFF, clears on rst or cnt_clr (cnt_clr wins over simultaneous increment).
- Not defined: ports and counters absent; no other behaviour changes.

## Test plan
- Program ch0: T1[hash(0x005,0x41)]=0x012, entry[0x012]={1,2'b10,40'h6162636465}; drive prehash_t1=0x005, byte 0x41, key 0x6162636465 → out_valid 4 cycles later, hit[1:0]=2'b01, suffix[1:0]=2'b10.
- Same key via T2 only, and via both with distinct suffixes 01/11 → hit 2'b10 suffix 01; then hit 2'b11 suffix from A.
- Entry valid = 0 with matching key → hit 0, suffix 0; ch1 stimulus simultaneous with ch0 → independent results.
- Continuous 16-beat stream with enable low for cycles 5-7 and one cfg_we in cycle 10 → 16 results, order preserved, latency 4 + stalls, in_ready low on those cycles.
- Assert rst with 3 beats in flight → outputs 0 immediately; no out_valid after release until new input.
- With CUCKOO_HIT_CNT_EN: preload hitting beats to counter 0xFFFFFFFE, send 3 more → 0xFFFFFFFF held; cnt_clr coincident with hit → 0.
